// File: rtl/servo_pkg.sv
`timescale 1ns/1ps
// servo_pkg
// Shared constants and types for the servo PWM stage.
//   TICKS_PER_FRAME : ticks per PWM period (20 ms at a 10 us tick)
//   MIN_PULSE       : pulse width in ticks for position 0 (1.0 ms)
//   POS_RANGE       : largest legal position; width = MIN_PULSE + pos
//   POS_W           : width of the position command
//   TIMEOUT_FRAMES  : frames without a loaded command before failsafe
//   NEUTRAL_WIDTH   : centre pulse width used at reset and in failsafe
package servo_pkg;

    localparam int TICKS_PER_FRAME = 2000;
    localparam int MIN_PULSE       = 100;
    localparam int POS_RANGE       = 100;
    localparam int POS_W           = 8;
    localparam int TIMEOUT_FRAMES  = 50;
    localparam int NEUTRAL_WIDTH   = MIN_PULSE + POS_RANGE / 2;
    localparam int CNT_W           = $clog2(TICKS_PER_FRAME);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } servo_state_t;

endpackage

// File: rtl/servo_cmd_shadow.sv
`timescale 1ns/1ps
// servo_cmd_shadow
// Position command intake: valid/ready handshake, clamp to POS_RANGE and a
// one-deep shadow register. The frame logic asks for a load at each frame
// start; a command arriving on that very edge bypasses the shadow.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   frame_evt      : high on the clk edge that begins a frame
//   cmd_valid/pos  : command from the source
//   cmd_ready      : high while no command is pending
//   load           : frame start carries a new command this edge
//   load_width     : pulse width (ticks) of that command
module servo_cmd_shadow #(
    parameter int MIN_PULSE = servo_pkg::MIN_PULSE,
    parameter int POS_RANGE = servo_pkg::POS_RANGE,
    parameter int POS_W     = servo_pkg::POS_W,
    parameter int CNT_W     = servo_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_evt,
    input  logic             cmd_valid,
    input  logic [POS_W-1:0] cmd_pos,
    output logic             cmd_ready,
    output logic             load,
    output logic [CNT_W-1:0] load_width
);
    import servo_pkg::*;

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(POS_RANGE);

    logic             pending;
    logic [POS_W-1:0] shadow;
    logic [POS_W-1:0] pos_clamped;
    logic             xfer;

    assign cmd_ready   = !pending;
    assign xfer        = cmd_valid && !pending;
    assign pos_clamped = (cmd_pos > POS_MAX) ? POS_MAX : cmd_pos;

    // A pending command wins; otherwise a transfer on the frame-start edge
    // goes straight through without ever setting pending.
    assign load       = frame_evt && (pending || xfer);
    assign load_width = CNT_W'(MIN_PULSE)
                      + (pending ? CNT_W'(shadow) : CNT_W'(pos_clamped));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            shadow  <= '0;
        end else if (frame_evt) begin
            pending <= 1'b0;
        end else if (xfer) begin
            pending <= 1'b1;
            shadow  <= pos_clamped;
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
`timescale 1ns/1ps
// servo_pwm_gen
// Hobby-servo PWM frame generator. Advances only on tick strobes; pulse
// width is taken from the command shadow at frame boundaries so a pulse is
// never glitched. A frame-count watchdog forces neutral width when commands
// stop arriving.
// Ports:
//   clk, reset   : 50 MHz clock, asynchronous active-low reset
//   tick         : one-clk enable strobe from the divider
//   enable       : level, 0 returns the block to idle on the next tick
//   cmd_valid    : position command valid
//   cmd_pos      : position command, 0..POS_RANGE (larger values clamp)
//   cmd_ready    : command can be accepted
//   pwm_out      : registered servo output
//   frame_start  : one-clk pulse on the edge that begins a frame
//   failsafe     : neutral width is being forced by the watchdog
//
// state | meaning
// IDLE  | output low, counter held at 0, waiting for enable on a tick
// RUN   | counting ticks through frames, output high while count < width
module servo_pwm_gen #(
    parameter int TICKS_PER_FRAME = servo_pkg::TICKS_PER_FRAME,
    parameter int MIN_PULSE       = servo_pkg::MIN_PULSE,
    parameter int POS_RANGE       = servo_pkg::POS_RANGE,
    parameter int POS_W           = servo_pkg::POS_W,
    parameter int TIMEOUT_FRAMES  = servo_pkg::TIMEOUT_FRAMES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             enable,
    input  logic             cmd_valid,
    input  logic [POS_W-1:0] cmd_pos,
    output logic             cmd_ready,
    output logic             pwm_out,
    output logic             frame_start,
    output logic             failsafe
);
    import servo_pkg::*;

    localparam int CNT_W = $clog2(TICKS_PER_FRAME);
    localparam int TO_W  = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [CNT_W-1:0] NEUTRAL  = CNT_W'(MIN_PULSE + POS_RANGE / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICKS_PER_FRAME - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_FRAMES);

    servo_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_step;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] width_next;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_next;
    logic             failsafe_next;
    logic             frame_evt;
    logic             load;
    logic [CNT_W-1:0] load_width;

    servo_cmd_shadow #(
        .MIN_PULSE (MIN_PULSE),
        .POS_RANGE (POS_RANGE),
        .POS_W     (POS_W),
        .CNT_W     (CNT_W)
    ) u_shadow (
        .clk        (clk),
        .reset      (reset),
        .frame_evt  (frame_evt),
        .cmd_valid  (cmd_valid),
        .cmd_pos    (cmd_pos),
        .cmd_ready  (cmd_ready),
        .load       (load),
        .load_width (load_width)
    );

    assign cnt_step = (cnt == LAST_CNT) ? '0 : cnt + 1'b1;

    // Frame start: leaving IDLE, or wrapping the counter while running.
    always_comb begin
        frame_evt = 1'b0;
        if (tick && enable) begin
            frame_evt = (state == IDLE) || (cnt == LAST_CNT);
        end
    end

    // Width and watchdog update, evaluated for the frame beginning now so
    // the new width already governs the first tick of that frame.
    always_comb begin
        to_next       = to_cnt;
        width_next    = width;
        failsafe_next = failsafe;
        if (load) begin
            to_next       = '0;
            width_next    = load_width;
            failsafe_next = 1'b0;
        end else if (frame_evt) begin
            if (to_cnt != TO_MAX) begin
                to_next = to_cnt + 1'b1;
            end
            if (to_next == TO_MAX) begin
                width_next    = NEUTRAL;
                failsafe_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            width       <= NEUTRAL;
            to_cnt      <= '0;
            failsafe    <= 1'b0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_evt;
            width       <= width_next;
            to_cnt      <= to_next;
            failsafe    <= failsafe_next;
            if (tick) begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (enable) begin
                            state   <= RUN;
                            pwm_out <= (width_next != '0);
                        end else begin
                            pwm_out <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (!enable) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            pwm_out <= 1'b0;
                        end else begin
                            cnt     <= cnt_step;
                            pwm_out <= (cnt_step < width_next);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        pwm_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
`timescale 1ns/1ps
// Directed bench for servo_pwm_gen. Frame length is shortened to 250 ticks
// so the 50-frame watchdog fits in a short run; widths are unchanged.
module tb_servo_pwm_gen;

    localparam int TPF = 250;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       enable;
    logic       cmd_valid;
    logic [7:0] cmd_pos;
    logic       cmd_ready;
    logic       pwm_out;
    logic       frame_start;
    logic       failsafe;

    int checks = 0;
    int errors = 0;
    int tick_div = 1;
    int tick_ph = 0;

    // frame monitor: width/length in clk cycles of the last completed frame
    int nfs = 0;
    int w_cur = 0;
    int len_cur = 0;
    int w_last = 0;
    int len_last = 0;

    servo_pwm_gen #(
        .TICKS_PER_FRAME (TPF),
        .MIN_PULSE       (100),
        .POS_RANGE       (100),
        .POS_W           (8),
        .TIMEOUT_FRAMES  (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .enable      (enable),
        .cmd_valid   (cmd_valid),
        .cmd_pos     (cmd_pos),
        .cmd_ready   (cmd_ready),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .failsafe    (failsafe)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_start) begin
            w_last   = w_cur;
            len_last = len_cur;
            w_cur    = int'(pwm_out);
            len_cur  = 1;
            nfs++;
        end else begin
            w_cur   += int'(pwm_out);
            len_cur += 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        tick_ph++;
        tick = ((tick_ph % tick_div) == 0);
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_fs(input int n);
        int target;
        int budget;
        target = nfs + n;
        budget = n * TPF * tick_div * 2 + 20;
        while (nfs < target && budget > 0) begin
            cyc();
            budget--;
        end
        if (nfs < target) chk("frame_start_timeout", nfs, target);
    endtask

    task automatic send(input int pos);
        int   guard;
        logic acc;
        cmd_valid = 1'b1;
        cmd_pos   = 8'(pos);
        guard     = 0;
        do begin
            acc = cmd_ready;
            cyc();
            guard++;
        end while (!acc && guard < 4 * TPF);
        cmd_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    initial begin
        int nfs0;
        reset     = 1'b0;
        tick      = 1'b1;
        enable    = 1'b1;
        cmd_valid = 1'b0;
        cmd_pos   = 8'd0;
        cycn(3);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_failsafe", failsafe, 0);
        chk("rst_cmd_ready", cmd_ready, 1);

        // free-running neutral frames
        reset = 1'b1;
        wait_fs(1);
        wait_fs(1);
        chk("neutral_width", w_last, 150);
        chk("frame_len", len_last, TPF);
        chk("idle_cmd_ready", cmd_ready, 1);

        // mid-frame command takes effect next frame
        cycn(20);
        send(0);
        chk("pending_ready_low", cmd_ready, 0);
        wait_fs(1);
        chk("cur_frame_kept", w_last, 150);
        chk("ready_after_load", cmd_ready, 1);
        wait_fs(1);
        chk("pos0_width", w_last, 100);

        // clamp
        cycn(20);
        send(250);
        wait_fs(1);
        wait_fs(1);
        chk("clamp_width", w_last, 200);

        // back-to-back: second command held until the next frame start
        cycn(10);
        send(40);
        chk("b2b_ready_low", cmd_ready, 0);
        nfs0 = nfs;
        send(60);
        chk("b2b_held_to_fs", nfs, nfs0 + 1);
        wait_fs(1);
        chk("b2b_first", w_last, 140);
        wait_fs(1);
        chk("b2b_second", w_last, 160);

        // bypass: command on the wrap edge (counter is 1 here)
        cycn(248);
        cmd_valid = 1'b1;
        cmd_pos   = 8'd30;
        chk("bypass_ready", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
        chk("bypass_edge_fs", frame_start, 1);
        chk("bypass_no_pending", cmd_ready, 1);
        wait_fs(1);
        wait_fs(1);
        chk("bypass_width", w_last, 130);

        // watchdog
        send(90);
        wait_fs(1);
        wait_fs(1);
        chk("wd_cmd_width", w_last, 190);
        chk("wd_fs_low", failsafe, 0);
        wait_fs(48);
        chk("wd_frame49", failsafe, 0);
        wait_fs(1);
        chk("wd_frame50_fs", failsafe, 1);
        chk("wd_frame50_prev", w_last, 190);
        wait_fs(1);
        chk("wd_neutral", w_last, 150);
        send(10);
        chk("wd_fs_until_load", failsafe, 1);
        wait_fs(1);
        chk("wd_fs_cleared", failsafe, 0);
        wait_fs(1);
        chk("wd_new_width", w_last, 110);

        // sparse ticks: every other clk counts
        tick_div = 2;
        wait_fs(1);
        wait_fs(1);
        chk("sparse_len", len_last, 2 * TPF);
        chk("sparse_width", w_last, 220);
        tick_div = 1;
        wait_fs(1);

        // enable drop mid-pulse, pending survives idle
        cycn(20);
        chk("pre_disable_pwm", pwm_out, 1);
        enable = 1'b0;
        cyc();
        chk("disable_pwm", pwm_out, 0);
        send(70);
        chk("idle_pending", cmd_ready, 0);
        cycn(5);
        chk("idle_pwm_low", pwm_out, 0);
        chk("idle_no_fs", frame_start, 0);
        chk("idle_pending_kept", cmd_ready, 0);
        enable = 1'b1;
        cyc();
        chk("reenable_fs", frame_start, 1);
        chk("reenable_pwm", pwm_out, 1);
        wait_fs(1);
        wait_fs(1);
        chk("reenable_width", w_last, 170);
        chk("reenable_len", len_last, TPF);

        // asynchronous reset mid-pulse with a pending command
        cycn(10);
        send(20);
        chk("pre_reset_pwm", pwm_out, 1);
        reset = 1'b0;
        #1;
        chk("areset_pwm", pwm_out, 0);
        chk("areset_ready", cmd_ready, 1);
        chk("areset_failsafe", failsafe, 0);
        chk("areset_fs", frame_start, 0);
        cycn(3);
        reset = 1'b1;
        wait_fs(1);
        wait_fs(1);
        chk("post_reset_width", w_last, 150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
Servo PWM stage directly downstream of the clock divider in the ServoController project. It consumes a single-cycle tick strobe derived from the divided clock and produces a standard hobby-servo frame: fixed period, with a high pulse whose width is set by a position command. Commands arrive over a valid/ready handshake and take effect only at frame boundaries, so pulses are never glitched. If commands stop arriving, a watchdog forces the servo to neutral.

Parameters:
TICKS_PER_FRAME, 2000, ticks per PWM period (20 ms at a 10 us tick)
MIN_PULSE, 100, pulse width in ticks for pos=0 (1.0 ms)
POS_RANGE, 100, maximum position value; pulse width = MIN_PULSE + pos (2.0 ms max)
POS_W, 8, width of the position command
TIMEOUT_FRAMES, 50, consecutive frames with no accepted command before failsafe (1 s)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous active-low reset
tick  in  1  one-clk-wide enable strobe from the divider stage; all timing advances only on clk edges where tick=1
enable  in  1  level; 0 forces idle
cmd_valid  in  1  position command valid
cmd_pos  in  POS_W  position command, 0..POS_RANGE
cmd_ready  out  1  block can accept a command
pwm_out  out  1  servo signal, registered
frame_start  out  1  one-clk pulse on the clk edge that begins a frame
failsafe  out  1  high while the neutral width is forced by the watchdog

Behaviour:
- Reset (reset=0, asynchronous): pwm_out=0, frame_start=0, failsafe=0, cmd_ready=1. Frame counter=0, pending flag=0, active width=MIN_PULSE+POS_RANGE/2 (neutral, 150), timeout count=0. State=IDLE.
- States: IDLE and RUN.
- IDLE: pwm_out=0 and the counter is held at 0. When enable=1 on a tick, go to RUN, begin frame 0, and pulse frame_start on that edge.
- RUN, on each tick: counter increments, wrapping from TICKS_PER_FRAME-1 to 0. The wrap edge is a frame start: frame_start=1 for that clk cycle.
- pwm_out is registered on tick edges as (new counter value < active width). The pulse is high for exactly width ticks per frame.
- enable=0 in RUN: return to IDLE on the next tick. pwm_out=0 immediately on that edge, even mid-pulse. The pending command is retained.
- Handshake:
  - cmd_ready = !pending. A transfer occurs on a clk edge with cmd_valid && cmd_ready.
  - cmd_pos > POS_RANGE is clamped to POS_RANGE at capture.
  - A transfer sets pending and stores the position in the shadow register.
  - cmd_valid with cmd_ready=0 is simply not accepted; the source must hold the command.
- Frame-start load: if pending, active width=MIN_PULSE+shadow, pending clears (cmd_ready rises the next cycle), timeout count clears, and failsafe clears. The new width governs the frame that starts on this edge.
- Simultaneous frame start and transfer with pending=0: the new command is loaded on that same frame start (the bypass path).
- Watchdog:
  - At each frame start with no load, timeout count increments, saturating.
  - When the count reaches TIMEOUT_FRAMES, active width=neutral and failsafe=1, from that frame start onward.
  - The next loaded command clears the failsafe.
  - The watchdog counts only in RUN.
- Width arithmetic:
  - Counter width CNT_W=$clog2(TICKS_PER_FRAME).
  - Width is computed in CNT_W bits, with no overflow given MIN_PULSE+POS_RANGE < TICKS_PER_FRAME.
- tick asserted on consecutive clk cycles is legal; each cycle counts as one tick.
- Reset mid-pulse drops pwm_out asynchronously; on release the block restarts in IDLE.

Decomposition:
- Shared package servo_pkg: the default timing constants (TICKS_PER_FRAME, MIN_PULSE, POS_RANGE, neutral width), the state enum {IDLE, RUN}, and the position width.
- One natural sub-module: servo_cmd_shadow, holding the handshake, clamp, and pending register and exposing load/width to the frame logic.
- Frame counter, watchdog, and output register stay in the top module.

Test Plan:
- Reset, enable=1, no commands, tick every 500 clk → pwm_out high 150 ticks per 2000-tick frame; frame_start every 2000 ticks; cmd_ready=1.
- Send cmd_pos=0 mid-frame → current frame keeps 150; next frame width=100. Send cmd_pos=250 → clamped, width=200.
- Two back-to-back commands (40, then 60) in one frame → first accepted, cmd_ready=0, second held until the next frame start; widths observed are 140 then 160.
- Command presented on the exact frame-start edge with pending=0 → applied to that frame (bypass).
- No commands for 50 frames after cmd_pos=90 (width 190) → frame 51 width=150, failsafe=1; a new cmd_pos=10 clears failsafe and gives width 110.
- Deassert enable mid-pulse → pwm_out low on the next tick, counter at 0. Reassert reset mid-pulse → pwm_out=0 immediately, all outputs at reset values.
